// File: rtl/rpn_cmd_sequencer_pkg.sv
// Shared token, opcode and FSM types for the RPN command sequencer.
package rpn_pkg;

    typedef enum logic [1:0] {PUSH = 2'd0, OP = 2'd1, EVAL = 2'd2, CLEAR = 2'd3} token_kind_e;
    typedef enum logic [1:0] {NOP = 2'd0, NEG = 2'd1, ADD = 2'd2, MUL = 2'd3} op_e;

    typedef struct packed {
        token_kind_e kind;
        logic [15:0] data;
    } token_t;

    localparam int MAX_STACK = 1000;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

endpackage

// File: rtl/rpn_cmd_sequencer_if.sv
// Token stream handshake into the sequencer.
interface rpn_cmd_sequencer_if;

    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [15:0] in_data;

    modport master (output in_valid, in_kind, in_data, input in_ready);
    modport slave  (input in_valid, in_kind, in_data, output in_ready);

endinterface

// File: rtl/rpn_token_fifo.sv
// Synchronous token FIFO, head-of-queue visible on rd_tok while non-empty.
module rpn_token_fifo
    import rpn_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  token_t wr_tok,
    input  logic   pop,
    output token_t rd_tok,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    token_t        mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          wr, rd;

    assign wr     = push && !full;
    assign rd     = pop && !empty;
    assign full   = (cnt == (AW+1)'(DEPTH));
    assign empty  = (cnt == '0);
    assign rd_tok = mem[rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
            case ({wr, rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= wr_tok;
    end

endmodule

// File: rtl/rpn_cmd_sequencer.sv
// Token-to-command sequencer for the step-clocked RPN calculator: legality via shadow depth,
// SETUP/STROBE/HOLD command timing and result snapshot on EVAL.
module rpn_cmd_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 2,
    parameter int MAX_STACK  = 1000
) (
    input  logic                clk,
    input  logic                rst,
    rpn_cmd_sequencer_if.slave  tok,
    output logic                calc_nrst,
    output logic                calc_step,
    output logic                calc_push,
    output logic [1:0]          calc_op,
    output logic [15:0]         calc_d,
    input  logic [15:0]         calc_out,
    input  logic [9:0]          calc_cnt,
    output logic                res_valid,
    output logic [15:0]         res_data,
    output logic [9:0]          res_depth,
    output logic                err,
    output logic                busy
);

    import rpn_pkg::*;

    localparam int         GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [9:0] MAX_D = 10'(MAX_STACK);

    state_e          state, state_n;
    logic [GW-1:0]   gap, gap_n;
    logic [9:0]      depth, depth_n, pend, pend_n;
    logic            step_n, nrst_n, push_n, res_valid_n, err_n, cmd;
    logic [1:0]      op_n;
    logic [15:0]     d_n, res_data_n;
    logic [9:0]      res_depth_n;
    token_t          head, wr_tok;
    logic            full, empty, wr_en, rd_en;

    assign tok.in_ready = !full;
    assign wr_en        = tok.in_valid && !full;
    assign wr_tok       = '{kind: token_kind_e'(tok.in_kind), data: tok.in_data};
    assign rd_en        = (state == IDLE) && !empty;
    assign busy         = !empty || (state != IDLE);

    rpn_token_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (wr_en),
        .wr_tok (wr_tok),
        .pop    (rd_en),
        .rd_tok (head),
        .full   (full),
        .empty  (empty)
    );

    // pend carries the post-command depth from the pop until it commits on entry to STROBE
    always_comb begin
        state_n     = state;
        gap_n       = gap;
        depth_n     = depth;
        pend_n      = pend;
        cmd         = 1'b0;
        step_n      = 1'b0;
        nrst_n      = calc_nrst;
        push_n      = calc_push;
        op_n        = calc_op;
        d_n         = calc_d;
        res_valid_n = 1'b0;
        res_data_n  = res_data;
        res_depth_n = res_depth;
        err_n       = 1'b0;
        unique case (state)
            IDLE: if (!empty) begin
                pend_n = depth;
                unique case (head.kind)
                    PUSH: begin
                        cmd    = (depth < MAX_D);
                        pend_n = depth + 10'd1;
                    end
                    OP: unique case (op_e'(head.data[1:0]))
                        NOP: cmd = 1'b1;
                        NEG: cmd = (depth >= 10'd1);
                        ADD: begin
                            cmd    = (depth >= 10'd2);
                            pend_n = depth - 10'd1;
                        end
                        MUL: cmd = (depth >= 10'd2);
                    endcase
                    EVAL: begin
                        res_valid_n = 1'b1;
                        res_data_n  = calc_out;
                        res_depth_n = calc_cnt;
                    end
                    CLEAR: begin
                        cmd    = 1'b1;
                        pend_n = '0;
                    end
                endcase
                if (cmd) begin
                    state_n = SETUP;
                    push_n  = (head.kind == PUSH);
                    op_n    = (head.kind == OP) ? head.data[1:0] : 2'd0;
                    nrst_n  = (head.kind != CLEAR);
                    if (head.kind == PUSH) d_n = head.data;
                end else if (head.kind != EVAL) begin
                    err_n = 1'b1;
                end
            end
            SETUP: begin
                state_n = STROBE;
                step_n  = 1'b1;
                depth_n = pend;
            end
            STROBE: begin
                state_n = HOLD;
                gap_n   = GW'(GAP_CYCLES - 1);
            end
            HOLD: begin
                if (gap == '0) begin
                    state_n = IDLE;
                    nrst_n  = 1'b1;
                    push_n  = 1'b0;
                    op_n    = 2'd0;
                end else begin
                    gap_n = gap - 1'b1;
                end
            end
        endcase
    end

    // Reset lands in SETUP with calc_nrst low, so the calculator reset command runs first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SETUP;
            gap       <= '0;
            depth     <= '0;
            pend      <= '0;
            calc_step <= 1'b0;
            calc_nrst <= 1'b0;
            calc_push <= 1'b0;
            calc_op   <= 2'd0;
            calc_d    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_depth <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            gap       <= gap_n;
            depth     <= depth_n;
            pend      <= pend_n;
            calc_step <= step_n;
            calc_nrst <= nrst_n;
            calc_push <= push_n;
            calc_op   <= op_n;
            calc_d    <= d_n;
            res_valid <= res_valid_n;
            res_data  <= res_data_n;
            res_depth <= res_depth_n;
            err       <= err_n;
        end
    end

endmodule

// File: tb/tb_rpn_cmd_sequencer.sv
// Directed bench for rpn_cmd_sequencer with a behavioural RPN calculator clocked by calc_step.
module tb_rpn_cmd_sequencer;

    localparam int GAP_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        calc_nrst, calc_step, calc_push, res_valid, err, busy;
    logic [1:0]  calc_op;
    logic [15:0] calc_d, calc_out, res_data;
    logic [9:0]  calc_cnt, res_depth;

    rpn_cmd_sequencer_if tok();

    rpn_cmd_sequencer #(.FIFO_DEPTH(8), .GAP_CYCLES(GAP_CYCLES), .MAX_STACK(1000)) dut (
        .clk       (clk),
        .rst       (rst),
        .tok       (tok),
        .calc_nrst (calc_nrst),
        .calc_step (calc_step),
        .calc_push (calc_push),
        .calc_op   (calc_op),
        .calc_d    (calc_d),
        .calc_out  (calc_out),
        .calc_cnt  (calc_cnt),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_depth (res_depth),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Calculator model: add pops two and pushes the sum, mul replaces top with next*top
    logic [15:0] stk [1024];
    logic [10:0] cnt_m = '0;
    logic [9:0]  top;
    assign top      = 10'(cnt_m - 11'd1);
    assign calc_out = (cnt_m == '0) ? 16'h0 : stk[top];
    assign calc_cnt = cnt_m[9:0];

    always @(posedge calc_step) begin
        if (!calc_nrst) cnt_m <= '0;
        else if (calc_push) begin
            stk[cnt_m[9:0]] <= calc_d;
            cnt_m <= cnt_m + 11'd1;
        end else begin
            case (calc_op)
                2'd1: if (cnt_m >= 11'd1) stk[top] <= -stk[top];
                2'd2: if (cnt_m >= 11'd2) begin
                    stk[top - 10'd1] <= stk[top - 10'd1] + stk[top];
                    cnt_m <= cnt_m - 11'd1;
                end
                2'd3: if (cnt_m >= 11'd2) stk[top] <= stk[top - 10'd1] * stk[top];
                default: ;
            endcase
        end
    end

    logic [31:0] strobe_n = '0, err_n = '0, res_n = '0;
    logic        lp [16];
    logic        ln [16];
    logic [1:0]  lo [16];
    logic [15:0] ld [16];

    always @(posedge calc_step) begin
        lp[strobe_n[3:0]] <= calc_push;
        ln[strobe_n[3:0]] <= calc_nrst;
        lo[strobe_n[3:0]] <= calc_op;
        ld[strobe_n[3:0]] <= calc_d;
        strobe_n <= strobe_n + 1;
    end

    always @(posedge clk) begin
        if (err)       err_n <= err_n + 1;
        if (res_valid) res_n <= res_n + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic burst(input logic [1:0] kind, input int base, input int n, output bit low_seen);
        int i = 0;
        int guard = 0;
        bit acc;
        low_seen = 0;
        tok.in_valid = 1'b1;
        tok.in_kind  = kind;
        tok.in_data  = 16'(base);
        while (i < n && guard < 20 * n + 100) begin
            acc = tok.in_ready;
            if (!acc) low_seen = 1;
            @(negedge clk);
            guard++;
            if (acc) begin
                i++;
                tok.in_data = 16'(base + i);
            end
        end
        tok.in_valid = 1'b0;
        check("accepted", i, n);
    endtask

    task automatic send(input logic [1:0] kind, input int data);
        bit unused;
        burst(kind, data, 1, unused);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check("idle_timeout", {31'b0, busy}, 0);
        repeat (2) @(negedge clk);
    endtask

    int          cyc;
    logic [31:0] s0, e0, r0;
    logic [3:0]  ix;
    bit          low;

    initial begin
        tok.in_valid = 1'b0;
        tok.in_kind  = 2'd0;
        tok.in_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_step",  calc_step, 0);
        check("rst_nrst",  calc_nrst, 0);
        check("rst_push",  calc_push, 0);
        check("rst_op",    calc_op, 0);
        check("rst_d",     calc_d, 0);
        check("rst_resv",  res_valid, 0);
        check("rst_resd",  res_data, 0);
        check("rst_resdp", res_depth, 0);
        check("rst_err",   err, 0);
        check("rst_ready", tok.in_ready, 1);

        // INIT sequence: SETUP overlaps reset, so STROBE + GAP HOLD + return to IDLE remain
        s0 = strobe_n;
        rst = 1'b0;
        wait_idle(cyc);
        check("init_cycles", cyc, 2 + GAP_CYCLES);
        check("init_strobes", strobe_n - s0, 1);
        ix = s0[3:0];
        check("init_nrst_at_step", ln[ix], 0);
        check("init_nrst_after", calc_nrst, 1);
        check("init_push", calc_push, 0);
        check("init_cnt", calc_cnt, 0);

        // PUSH 5, PUSH 7, ADD, EVAL
        s0 = strobe_n; r0 = res_n;
        send(2'd0, 5); send(2'd0, 7); send(2'd1, 2); send(2'd2, 0);
        wait_idle(cyc);
        check("t2_strobes", strobe_n - s0, 3);
        ix = s0[3:0];        check("t2_push0", lp[ix], 1); check("t2_d0", ld[ix], 5);
        ix = 4'(s0 + 1);     check("t2_push1", lp[ix], 1); check("t2_d1", ld[ix], 7);
        ix = 4'(s0 + 2);     check("t2_push2", lp[ix], 0); check("t2_op2", lo[ix], 2);
        check("t2_resn", res_n - r0, 1);
        check("t2_res_data", res_data, 12);
        check("t2_res_depth", res_depth, 1);
        check("t2_shadow", dut.depth, calc_cnt);

        // PUSH 6, NEG, PUSH 7, MUL, NOP, EVAL: -6*7 = -42, depth 3
        s0 = strobe_n; r0 = res_n;
        send(2'd0, 6); send(2'd1, 1); send(2'd0, 7); send(2'd1, 3); send(2'd1, 0); send(2'd2, 0);
        wait_idle(cyc);
        check("t3_strobes", strobe_n - s0, 5);
        ix = 4'(s0 + 4);     check("t3_nop_op", lo[ix], 0);
        check("t3_res_data", res_data, 16'hFFD6);
        check("t3_res_depth", res_depth, 3);
        check("t3_shadow", dut.depth, 3);

        // Illegal NEG at depth 0 and ADD at depth 1
        send(2'd3, 0);
        wait_idle(cyc);
        check("clr_cnt", calc_cnt, 0);
        s0 = strobe_n; e0 = err_n;
        send(2'd1, 1);
        wait_idle(cyc);
        check("neg0_err", err_n - e0, 1);
        check("neg0_nostep", strobe_n - s0, 0);
        check("neg0_depth", dut.depth, 0);
        send(2'd0, 3);
        wait_idle(cyc);
        s0 = strobe_n; e0 = err_n;
        send(2'd1, 2);
        wait_idle(cyc);
        check("add1_err", err_n - e0, 1);
        check("add1_nostep", strobe_n - s0, 0);
        check("add1_depth", dut.depth, 1);
        check("add1_cnt", calc_cnt, 1);

        // Burst of 16 pushes with in_valid held: FIFO fills, all issued in order
        s0 = strobe_n;
        burst(2'd0, 100, 16, low);
        wait_idle(cyc);
        check("burst_ready_low", low, 1);
        check("burst_strobes", strobe_n - s0, 16);
        for (int k = 0; k < 16; k++) begin
            ix = 4'(s0 + 32'(k));
            check("burst_order", ld[ix], 32'(100 + k));
        end
        check("burst_cnt", calc_cnt, 17);
        check("burst_top", calc_out, 115);

        // Fill to capacity, then overflow
        send(2'd3, 0);
        burst(2'd0, 0, 1000, low);
        wait_idle(cyc);
        check("full_cnt", calc_cnt, 1000);
        check("full_shadow", dut.depth, 1000);
        s0 = strobe_n; e0 = err_n;
        send(2'd0, 1);
        wait_idle(cyc);
        check("ovf_err", err_n - e0, 1);
        check("ovf_nostep", strobe_n - s0, 0);
        check("ovf_cnt", calc_cnt, 1000);
        r0 = res_n;
        send(2'd3, 0); send(2'd2, 0);
        wait_idle(cyc);
        check("clr_resn", res_n - r0, 1);
        check("clr_res_depth", res_depth, 0);
        check("clr_res_data", res_data, 0);

        // Reset during STROBE with a token still queued
        send(2'd0, 9); send(2'd0, 10);
        cyc = 0;
        while (!calc_step && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("strobe_seen", calc_step, 1);
        rst = 1'b1;
        #1;
        check("mid_step", calc_step, 0);
        check("mid_nrst", calc_nrst, 0);
        check("mid_push", calc_push, 0);
        check("mid_fifo_empty", dut.u_fifo.empty, 1);
        check("mid_shadow", dut.depth, 0);
        @(negedge clk);
        s0 = strobe_n;
        rst = 1'b0;
        wait_idle(cyc);
        check("reinit_strobes", strobe_n - s0, 1);
        ix = s0[3:0];
        check("reinit_nrst", ln[ix], 0);
        check("reinit_cnt", calc_cnt, 0);
        check("reinit_shadow", dut.depth, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rpn_cmd_sequencer.md
Name: rpn_cmd_sequencer

Overview:
Upstream feeder for the RPN stack calculator.
- Accepts a stream of tokens (push value / operation / evaluate / clear) over a valid/ready handshake and buffers them in a small FIFO.
- Converts each legal token into a correctly timed command (calc_push, calc_op, calc_d, calc_step pulse) for the calculator, which is clocked by step.
- Keeps a shadow stack depth, rejects underflow/overflow tokens, and snapshots the calculator result on evaluate tokens.

Parameters:
FIFO_DEPTH, 8, token FIFO entries (power of 2).
GAP_CYCLES, 2, clk cycles calc_step stays low after each strobe before the next command (>=1).
MAX_STACK, 1000, calculator stack capacity.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  token valid
in_ready  output  1  token accepted when in_valid & in_ready
in_kind  input  2  0=PUSH, 1=OP, 2=EVAL, 3=CLEAR
in_data  input  16  PUSH: value; OP: bits[1:0]=op (0 nop, 1 neg, 2 add, 3 mul); else ignored
calc_nrst  output  1  calculator reset, active-low, sampled on calc_step rise
calc_step  output  1  calculator clock strobe, registered
calc_push  output  1  command: push
calc_op  output  2  command: operation
calc_d  output  16  command: push data
calc_out  input  16  calculator top of stack
calc_cnt  input  10  calculator depth
res_valid  output  1  one-cycle pulse, result captured
res_data  output  16  captured calc_out
res_depth  output  10  captured calc_cnt
err  output  1  one-cycle pulse, token rejected
busy  output  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset values:
  - calc_step=0, calc_nrst=0, calc_push=0, calc_op=0, calc_d=0.
  - res_valid=0, res_data=0, res_depth=0, err=0.
  - FIFO empty, shadow depth=0, FSM=INIT_SETUP.
- After reset, one calculator reset command runs (calc_nrst=0 through SETUP/STROBE/HOLD), then calc_nrst=1.
- FIFO:
  - in_ready = !full.
  - Simultaneous write and read while full is not allowed: in_ready=0.
  - Simultaneous write and read while non-full and non-empty is allowed; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP, STROBE, HOLD (INIT_* share SETUP/STROBE/HOLD with calc_nrst=0).
- IDLE with FIFO non-empty: pop the head token and classify it in the same cycle.
  - PUSH:
    - legal iff depth<MAX_STACK.
    - calc_push=1, calc_d=in_data; depth+1.
  - OP nop: always legal; depth unchanged.
  - OP neg: legal iff depth>=1; depth unchanged.
  - OP add: legal iff depth>=2; depth-1.
  - OP mul: legal iff depth>=2; depth unchanged.
  - EVAL: no strobe. Next cycle res_data<=calc_out, res_depth<=calc_cnt, res_valid=1. Return to IDLE.
  - CLEAR:
    - calc_nrst=0 for one command sequence; depth<=0.
    - Always legal.
  - Illegal token: dropped, err=1 for one cycle, no strobe, depth unchanged, stay IDLE.
- Command sequence timing for legal commands:
  - SETUP: outputs driven, calc_step=0, 1 cycle.
  - STROBE: calc_step=1, 1 cycle.
  - HOLD: calc_step=0, GAP_CYCLES cycles.
  - Then back to IDLE; calc_push/op/d/nrst return to 0/0/hold/1.
  - Command outputs are stable from SETUP through the end of HOLD.
- Throughput: one command per 2+GAP_CYCLES+1 clk cycles (IDLE pop included).
- Shadow depth (10 bits) updates on entry to STROBE. It must equal calc_cnt in IDLE; the bench checks this.
- Reset mid-sequence: all outputs go to reset values immediately, FIFO is flushed, and the INIT sequence reruns.
- res_data/res_depth hold their value until the next EVAL.

Decomposition:
- Package rpn_pkg:
  - token_kind_e {PUSH, OP, EVAL, CLEAR}
  - op_e {NOP, NEG, ADD, MUL}
  - packed token_t {kind, data}
  - MAX_STACK constant
  - state_e
- Sub-module rpn_token_fifo: parameterised synchronous FIFO of token_t with async active-high reset, push/pop/full/empty.
- Top: FSM, legality check, shadow depth, result capture.

Test Plan:
- Reset then idle:
  - calc_nrst low through exactly one calc_step pulse, then high.
  - All other outputs 0; busy falls after 2+GAP_CYCLES+1 cycles.
- Tokens PUSH 5, PUSH 7, OP add, EVAL:
  - three strobes, calc_push 1,1,0, calc_op=2 on the third.
  - res_valid pulse with res_data=12 (calculator model), res_depth=1.
- OP neg at depth 0, then OP add at depth 1:
  - err pulses twice, no calc_step, depth unchanged.
- Burst of 10 tokens with in_valid held:
  - in_ready drops after 8 accepted; all 10 issued in order; no token lost.
- 1000 PUSH then one more PUSH:
  - 1001st rejected with err, calc_cnt=1000.
  - CLEAR then EVAL gives res_depth=0.
- Assert rst during STROBE:
  - calc_step=0 same cycle, FIFO empty, INIT sequence repeats, shadow depth=0.
